// File: rtl/multi_deque_pkg.sv
// Shared definitions for the multi-channel deque.
//   op_e    : command encoding carried on the 2-bit op bus
//   is_pop  : true for POP_BACK / POP_FRONT (op[1] set)
//   sel_w   : width of a channel-select bus for a given channel count (min 1)
package multi_deque_pkg;

    typedef enum logic [1:0] {
        OP_PUSH_BACK  = 2'b00,
        OP_PUSH_FRONT = 2'b01,
        OP_POP_BACK   = 2'b10,
        OP_POP_FRONT  = 2'b11
    } op_e;

    function automatic logic is_pop(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deque_channel.sv
// One double-ended queue held as a circular buffer.
//   clk, rst   : clock, synchronous active-high reset (clears head/count only)
//   sel        : this channel is addressed this cycle
//   in_valid   : command strobe; op selects push/pop at front/back
//   flush      : empty the channel when selected; overrides in_valid
//   data_in    : push data
//   rd_data    : combinational word at the index the current op would pop
//   pop_ok     : a pop is accepted this cycle
//   rej        : the selected command is rejected (push when full / pop when empty)
//   empty/full : derived from the registered count
module deque_channel
    import multi_deque_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] rd_data,
    output logic             pop_ok,
    output logic             rej,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    cnt_lo;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic             wr_en;
    logic             cmd;

    // count==DEPTH truncates to 0 here, which is harmless: a full channel
    // never accepts a push, and pop-back uses cnt_lo-1 which wraps correctly.
    assign cnt_lo = count_q[AW-1:0];
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign rd_idx = (op_e'(op) == OP_POP_BACK) ? (head_q + cnt_lo - AW'(1)) : head_q;
    assign rd_data = mem_q[rd_idx];

    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = head_q + cnt_lo;
        pop_ok  = 1'b0;
        rej     = 1'b0;
        cmd     = sel & in_valid & ~flush;

        if (sel && flush) begin
            head_d  = '0;
            count_d = '0;
        end else if (cmd) begin
            case (op_e'(op))
                OP_PUSH_BACK: begin
                    if (full) begin
                        rej = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + CW'(1);
                    end
                end
                OP_PUSH_FRONT: begin
                    if (full) begin
                        rej = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = head_q - AW'(1);
                        head_d  = head_q - AW'(1);
                        count_d = count_q + CW'(1);
                    end
                end
                OP_POP_BACK: begin
                    if (empty) begin
                        rej = 1'b1;
                    end else begin
                        pop_ok  = 1'b1;
                        count_d = count_q - CW'(1);
                    end
                end
                default: begin
                    if (empty) begin
                        rej = 1'b1;
                    end else begin
                        pop_ok  = 1'b1;
                        head_d  = head_q + AW'(1);
                        count_d = count_q - CW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= data_in;
        end
    end

endmodule

// File: rtl/multi_deque.sv
// NUM_CH independent deques behind one command port and one data bus.
//   clk, rst  : clock, synchronous active-high reset
//   ch_sel    : channel addressed by in_valid / flush
//   in_valid  : command strobe; op = PUSH_BACK/PUSH_FRONT/POP_BACK/POP_FRONT
//   flush     : empty the selected channel; overrides in_valid
//   data_in   : push data
//   data_out  : registered popped word, held until the next successful pop
//   out_valid : one-cycle pulse after a successful pop
//   err       : one-cycle pulse after a rejected command
//   empty/full: per-channel status from registered counts
module multi_deque
    import multi_deque_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    localparam int CH_W  = sel_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              in_valid,
    input  logic [1:0]        op,
    input  logic              flush,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              out_valid,
    output logic              err,
    output logic [NUM_CH-1:0] empty,
    output logic [NUM_CH-1:0] full
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] pop_ok;
    logic [NUM_CH-1:0] rej;
    logic [WIDTH-1:0]  rd_data [NUM_CH];
    logic [WIDTH-1:0]  rd_mux;
    logic              range_err;

    logic [WIDTH-1:0]  data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign sel[i] = ({1'b0, ch_sel} == (CH_W + 1)'(i));

        deque_channel #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .sel      (sel[i]),
            .in_valid (in_valid),
            .op       (op),
            .flush    (flush),
            .data_in  (data_in),
            .rd_data  (rd_data[i]),
            .pop_ok   (pop_ok[i]),
            .rej      (rej[i]),
            .empty    (empty[i]),
            .full     (full[i])
        );
    end

    assign range_err = (in_valid | flush) && ({1'b0, ch_sel} >= NUM_CH_L);

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel[i]) rd_mux = rd_data[i];
        end
    end

    always_comb begin
        out_valid_d = |pop_ok;
        err_d       = (|rej) | range_err;
        data_out_d  = (|pop_ok) ? rd_mux : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_multi_deque.sv
// Self-checking bench for multi_deque: directed scenarios followed by a
// random command stream, all compared against queue-based reference deques.
module tb_multi_deque;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 16;
    localparam int WIDTH  = 8;
    localparam int CH_W   = 2;

    localparam logic [1:0] PB  = 2'b00;
    localparam logic [1:0] PF  = 2'b01;
    localparam logic [1:0] OB  = 2'b10;
    localparam logic [1:0] OF  = 2'b11;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH_W-1:0]   ch_sel;
    logic              in_valid;
    logic [1:0]        op;
    logic              flush;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              out_valid;
    logic              err;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;

    multi_deque #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_sel    (ch_sel),
        .in_valid  (in_valid),
        .op        (op),
        .flush     (flush),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .err       (err),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [NUM_CH][$];
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ov;
    logic             exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] e_empty;
        logic [NUM_CH-1:0] e_full;
        for (int c = 0; c < NUM_CH; c++) begin
            e_empty[c] = (mq[c].size() == 0);
            e_full[c]  = (mq[c].size() == DEPTH);
        end
        check_eq({tag, "/data_out"},  32'(data_out),  32'(exp_dout));
        check_eq({tag, "/out_valid"}, 32'(out_valid), 32'(exp_ov));
        check_eq({tag, "/err"},       32'(err),       32'(exp_err));
        check_eq({tag, "/empty"},     32'(empty),     32'(e_empty));
        check_eq({tag, "/full"},      32'(full),      32'(e_full));
    endtask

    // Apply one command for one clock, advance the reference model, check.
    task automatic step(input string tag, input int ch, input bit v, input logic [1:0] o,
                        input bit f, input logic [WIDTH-1:0] d);
        rst      = 1'b0;
        ch_sel   = CH_W'(ch);
        in_valid = v;
        op       = o;
        flush    = f;
        data_in  = d;
        exp_ov   = 1'b0;
        exp_err  = 1'b0;
        if (f || v) begin
            if (ch >= NUM_CH) begin
                exp_err = 1'b1;
            end else if (f) begin
                mq[ch].delete();
            end else if (o[1] == 1'b0) begin
                if (mq[ch].size() == DEPTH) exp_err = 1'b1;
                else if (o == PB) mq[ch].push_back(d);
                else mq[ch].push_front(d);
            end else begin
                if (mq[ch].size() == 0) begin
                    exp_err = 1'b1;
                end else begin
                    exp_ov = 1'b1;
                    if (o == OB) exp_dout = mq[ch].pop_back();
                    else exp_dout = mq[ch].pop_front();
                end
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag, input int ch, input bit v, input logic [1:0] o);
        rst      = 1'b1;
        ch_sel   = CH_W'(ch);
        in_valid = v;
        op       = o;
        flush    = 1'b0;
        data_in  = 8'hEE;
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        exp_dout = '0;
        exp_ov   = 1'b0;
        exp_err  = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ch_sel = '0; in_valid = 1'b0; op = PB; flush = 1'b0; data_in = '0;
        exp_dout = '0; exp_ov = 1'b0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset", 0, 1'b0, PB);

        // 1: mixed back/front pushes drained from the front
        step("t1_pb11", 0, 1, PB, 0, 8'h11);
        step("t1_pb22", 0, 1, PB, 0, 8'h22);
        step("t1_pf00", 0, 1, PF, 0, 8'h00);
        step("t1_pop0", 0, 1, OF, 0, 8'h00);
        check_eq("t1_lit0", 32'(data_out), 32'h00);
        step("t1_pop1", 0, 1, OF, 0, 8'h00);
        check_eq("t1_lit1", 32'(data_out), 32'h11);
        step("t1_pop2", 0, 1, OF, 0, 8'h00);
        check_eq("t1_lit2", 32'(data_out), 32'h22);
        step("t1_idle", 0, 0, PB, 0, 8'h00);
        check_eq("t1_empty0", 32'(empty[0]), 32'h1);

        // 2: stack order on ch1
        step("t2_pbA1", 1, 1, PB, 0, 8'hA1);
        step("t2_pbA2", 1, 1, PB, 0, 8'hA2);
        step("t2_ob0", 1, 1, OB, 0, 8'h00);
        check_eq("t2_lit0", 32'(data_out), 32'hA2);
        step("t2_ob1", 1, 1, OB, 0, 8'h00);
        check_eq("t2_lit1", 32'(data_out), 32'hA1);

        // 3: fill ch0 from the front, overflow, pop the oldest from the back
        for (int i = 0; i < DEPTH; i++) step("t3_fill", 0, 1, PF, 0, 8'(i));
        check_eq("t3_full0", 32'(full[0]), 32'h1);
        step("t3_over", 0, 1, PF, 0, 8'hFF);
        check_eq("t3_err", 32'(err), 32'h1);
        step("t3_ob", 0, 1, OB, 0, 8'h00);
        check_eq("t3_lit", 32'(data_out), 32'h00);

        // 4: pop on empty ch1
        step("t4_popempty", 1, 1, OF, 0, 8'h00);
        check_eq("t4_err", 32'(err), 32'h1);
        check_eq("t4_keep", 32'(data_out), 32'h00);

        // 5: flush overrides a same-cycle push
        step("t5_flush_a", 0, 0, PB, 1, 8'h00);
        step("t5_p0", 0, 1, PB, 0, 8'h01);
        step("t5_p1", 0, 1, PB, 0, 8'h02);
        step("t5_p2", 0, 1, PF, 0, 8'h03);
        step("t5_flush", 0, 1, PB, 1, 8'h99);
        check_eq("t5_empty0", 32'(empty[0]), 32'h1);
        check_eq("t5_noerr", 32'(err), 32'h0);
        step("t5_pb5A", 0, 1, PB, 0, 8'h5A);
        step("t5_of", 0, 1, OF, 0, 8'h00);
        check_eq("t5_lit", 32'(data_out), 32'h5A);

        // out-of-range channel for a command and for a flush
        step("rng_push", 3, 1, PB, 0, 8'h42);
        check_eq("rng_err", 32'(err), 32'h1);
        step("rng_flush", 3, 0, PB, 1, 8'h00);

        // 6: reset during a pop on a nonempty channel
        step("t6_pb", 2, 1, PB, 0, 8'h77);
        do_reset("t6_rst", 2, 1, OF);
        check_eq("t6_ov", 32'(out_valid), 32'h0);
        check_eq("t6_dout", 32'(data_out), 32'h00);
        check_eq("t6_empty", 32'(empty), 32'h7);

        // random stream; push-heavy and pop-heavy phases to reach full/empty
        for (int n = 0; n < 3000; n++) begin
            int r;
            int ch;
            int push_pct;
            logic [1:0] o;
            push_pct = ((n / 300) % 2 == 0) ? 75 : 30;
            r  = $urandom_range(0, 19);
            ch = (r == 0) ? 3 : (r % NUM_CH);
            if ($urandom_range(0, 99) < push_pct) o = 2'($urandom_range(0, 1));
            else o = 2'($urandom_range(2, 3));
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst", ch, 1, o);
            end else begin
                step("rnd", ch, ($urandom_range(0, 9) < 8), o, ($urandom_range(0, 39) == 0),
                     8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
